axi_uart_fifo: RTL

Parametrised UART with ready/valid byte streams and independent TX/RX FIFOs. It is the successor to `axi_uart` and sits between the board top level (`serial_out`/`serial_in` to GPIO) and `yarvi_soc` (tx/rx streams). Over `axi_uart` it adds:
- configurable frame format and baud rate,
- buffering in both directions,
- RX glitch rejection,
- sticky error reporting.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 85 ++++++++
 rtl/axi_uart_fifo.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for axi_uart_fifo: parity encodings, the FSM
//            state enum used by both the TX and RX engines, and the
//            clocks-per-bit computation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int uart_div(input int clock_hz, input int baud);
    return (clock_hz + baud / 2) / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with show-ahead read data and registered
//            level/full/empty flags.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            i_push/i_push_data - write strobe and data (ignored when full)
//            i_pop              - read strobe (ignored when empty)
//            o_pop_data         - head entry, valid whenever !o_empty
//            o_level            - occupancy, 0 .. 2**LOG2
//            o_full, o_empty    - registered status flags
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [LOG2:0]    o_level,
  output logic             o_full,
  output logic             o_empty
);

  localparam int            c_DEPTH      = 1 << LOG2;
  localparam logic [LOG2:0] c_LEVEL_FULL = (LOG2 + 1)'(c_DEPTH);

  logic [WIDTH-1:0] r_mem [c_DEPTH];
  logic [LOG2:0]    r_wr_ptr;
  logic [LOG2:0]    r_rd_ptr;
  logic [LOG2:0]    r_level;
  logic             r_full;
  logic             r_empty;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [LOG2:0]    w_wr_nx;
  logic [LOG2:0]    w_rd_nx;
  logic [LOG2:0]    w_level_nx;

  assign w_push_ok  = i_push & ~r_full;
  assign w_pop_ok   = i_pop & ~r_empty;
  // Pointers carry one extra bit so that full and empty differ.
  assign w_wr_nx    = r_wr_ptr + (LOG2 + 1)'(w_push_ok);
  assign w_rd_nx    = r_rd_ptr + (LOG2 + 1)'(w_pop_ok);
  assign w_level_nx = w_wr_nx - w_rd_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      // Full reads asserted while in reset so no writer is accepted until
      // the first clock edge after release.
      r_full   <= 1'b1;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nx;
      r_rd_ptr <= w_rd_nx;
      r_level  <= w_level_nx;
      r_full   <= (w_level_nx == c_LEVEL_FULL);
      r_empty  <= (w_level_nx == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[LOG2-1:0]] <= i_push_data;
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr[LOG2-1:0]];
  assign o_level    = r_level;
  assign o_full     = r_full;
  assign o_empty    = r_empty;

endmodule

`default_nettype wire

// File: rtl/axi_uart_fifo.sv
// ============================================================================
// Module   : axi_uart_fifo
// Purpose  : UART with ready/valid byte streams, TX/RX FIFOs, configurable
//            frame format, RX glitch rejection and sticky error flags.
// Ports    : clock, reset_n             - clock, async active-low reset
//            tx_valid/tx_ready/tx_data  - transmit stream into TX FIFO
//            rx_valid/rx_ready/rx_data  - receive stream out of RX FIFO
//            err_clear                  - clears sticky error flags
//            framing_err/parity_err/overrun_err - sticky error flags
//            tx_level, rx_level         - FIFO occupancies
//            serial_out, serial_in      - line pins (idle high)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_uart_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_LOG2 = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 err_clear,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic [FIFO_LOG2:0]   tx_level,
  output logic [FIFO_LOG2:0]   rx_level,
  output logic                 serial_out,
  input  logic                 serial_in
);

  localparam int                c_DIV       = uart_div(CLOCK_HZ, BAUD);
  localparam int                c_BAUD_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_DIV - 1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_HALF = c_BAUD_W'((c_DIV / 2 > 0) ? (c_DIV / 2 - 1) : 0);
  localparam logic [3:0]        c_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        c_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic              c_PAR_EN    = (PARITY != PAR_NONE);
  localparam logic              c_PAR_INV   = (PARITY == PAR_ODD);

  // ---------------------------------------------------------------- FIFOs
  logic                 w_tx_full, w_tx_empty, w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;
  logic                 w_rx_full, w_rx_empty, w_rx_push;
  logic [DATA_BITS-1:0] r_rx_shift;

  sync_fifo #(.WIDTH(DATA_BITS), .LOG2(FIFO_LOG2)) u_tx_fifo (
    .clk        (clock),
    .rst_n      (reset_n),
    .i_push     (tx_valid),
    .i_push_data(tx_data),
    .i_pop      (w_tx_pop),
    .o_pop_data (w_tx_head),
    .o_level    (tx_level),
    .o_full     (w_tx_full),
    .o_empty    (w_tx_empty)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .LOG2(FIFO_LOG2)) u_rx_fifo (
    .clk        (clock),
    .rst_n      (reset_n),
    .i_push     (w_rx_push),
    .i_push_data(r_rx_shift),
    .i_pop      (rx_ready),
    .o_pop_data (rx_data),
    .o_level    (rx_level),
    .o_full     (w_rx_full),
    .o_empty    (w_rx_empty)
  );

  assign tx_ready = ~w_tx_full;
  assign rx_valid = ~w_rx_empty;

  // ------------------------------------------------------------- TX engine
  uart_state_t          r_tx_state, w_tx_state_nx;
  logic [c_BAUD_W-1:0]  r_tx_baud, w_tx_baud_nx;
  logic [3:0]           r_tx_bit, w_tx_bit_nx;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nx;
  logic                 r_tx_par, w_tx_par_nx;
  logic                 r_serial_out, w_tx_line, w_tx_tick;

  assign w_tx_tick = (r_tx_baud == c_BAUD_LAST);

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_baud_nx  = (r_tx_state == ST_IDLE || w_tx_tick) ? '0 : r_tx_baud + 1'b1;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_shift_nx = r_tx_shift;
    w_tx_par_nx   = r_tx_par;
    w_tx_pop      = 1'b0;
    w_tx_line     = 1'b1;
    case (r_tx_state)
      ST_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop      = 1'b1;
          w_tx_shift_nx = w_tx_head;
          w_tx_par_nx   = (^w_tx_head) ^ c_PAR_INV;
          w_tx_bit_nx   = '0;
          w_tx_state_nx = ST_START;
        end
      end
      ST_START: begin
        w_tx_line = 1'b0;
        if (w_tx_tick) begin
          w_tx_bit_nx   = '0;
          w_tx_state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_tick) begin
          w_tx_shift_nx = r_tx_shift >> 1;
          if (r_tx_bit == c_DATA_LAST) begin
            w_tx_bit_nx   = '0;
            w_tx_state_nx = c_PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            w_tx_bit_nx = r_tx_bit + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        w_tx_line = r_tx_par;
        if (w_tx_tick) begin
          w_tx_bit_nx   = '0;
          w_tx_state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tx_tick) begin
          if (r_tx_bit == c_STOP_LAST) begin
            w_tx_bit_nx = '0;
            // Chain straight into the next frame when data is waiting.
            if (!w_tx_empty) begin
              w_tx_pop      = 1'b1;
              w_tx_shift_nx = w_tx_head;
              w_tx_par_nx   = (^w_tx_head) ^ c_PAR_INV;
              w_tx_state_nx = ST_START;
            end else begin
              w_tx_state_nx = ST_IDLE;
            end
          end else begin
            w_tx_bit_nx = r_tx_bit + 1'b1;
          end
        end
      end
      default: w_tx_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state   <= ST_IDLE;
      r_tx_baud    <= '0;
      r_tx_bit     <= '0;
      r_tx_shift   <= '0;
      r_tx_par     <= 1'b0;
      r_serial_out <= 1'b1;
    end else begin
      r_tx_state   <= w_tx_state_nx;
      r_tx_baud    <= w_tx_baud_nx;
      r_tx_bit     <= w_tx_bit_nx;
      r_tx_shift   <= w_tx_shift_nx;
      r_tx_par     <= w_tx_par_nx;
      // Line is registered from the state, so it trails the state by a clock.
      r_serial_out <= w_tx_line;
    end
  end

  assign serial_out = r_serial_out;

  // ------------------------------------------------------------- RX engine
  logic                 r_rx_meta, r_rx_sync, r_rx_armed, w_rx_armed_nx;
  uart_state_t          r_rx_state, w_rx_state_nx;
  logic [c_BAUD_W-1:0]  r_rx_baud, w_rx_baud_nx;
  logic [3:0]           r_rx_bit, w_rx_bit_nx;
  logic [DATA_BITS-1:0] w_rx_shift_nx;
  logic                 r_rx_par_bit, w_rx_par_bit_nx;
  logic                 w_rx_tick;
  logic                 w_set_frame, w_set_par, w_set_ovr;
  logic                 r_framing_err, r_parity_err, r_overrun_err;

  assign w_rx_tick = (r_rx_baud == c_BAUD_LAST);

  always_comb begin
    w_rx_state_nx   = r_rx_state;
    w_rx_baud_nx    = (r_rx_state == ST_IDLE || w_rx_tick) ? '0 : r_rx_baud + 1'b1;
    w_rx_bit_nx     = r_rx_bit;
    w_rx_shift_nx   = r_rx_shift;
    w_rx_par_bit_nx = r_rx_par_bit;
    w_rx_armed_nx   = r_rx_armed;
    w_rx_push       = 1'b0;
    w_set_frame     = 1'b0;
    w_set_par       = 1'b0;
    w_set_ovr       = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        // Armed only after the line has been seen high, so a held-low line
        // (break or bad stop) cannot retrigger a frame.
        if (!r_rx_armed) begin
          w_rx_armed_nx = r_rx_sync;
        end else if (!r_rx_sync) begin
          w_rx_armed_nx = 1'b0;
          w_rx_state_nx = ST_START;
        end
      end
      ST_START: begin
        // Mid-bit check of the start bit; a high line means a glitch.
        if (r_rx_baud == c_BAUD_HALF) begin
          w_rx_baud_nx = '0;
          w_rx_bit_nx  = '0;
          w_rx_state_nx = r_rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_rx_tick) begin
          w_rx_shift_nx = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bit == c_DATA_LAST) begin
            w_rx_bit_nx   = '0;
            w_rx_state_nx = c_PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            w_rx_bit_nx = r_rx_bit + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_rx_tick) begin
          w_rx_par_bit_nx = r_rx_sync;
          w_rx_state_nx   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_rx_tick) begin
          w_rx_push     = ~w_rx_full;
          w_set_ovr     = w_rx_full;
          w_set_frame   = ~r_rx_sync;
          w_set_par     = c_PAR_EN & (r_rx_par_bit != ((^r_rx_shift) ^ c_PAR_INV));
          w_rx_state_nx = ST_IDLE;
        end
      end
      default: w_rx_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta     <= 1'b1;
      r_rx_sync     <= 1'b1;
      r_rx_armed    <= 1'b0;
      r_rx_state    <= ST_IDLE;
      r_rx_baud     <= '0;
      r_rx_bit      <= '0;
      r_rx_shift    <= '0;
      r_rx_par_bit  <= 1'b0;
      r_framing_err <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_rx_meta     <= serial_in;
      r_rx_sync     <= r_rx_meta;
      r_rx_armed    <= w_rx_armed_nx;
      r_rx_state    <= w_rx_state_nx;
      r_rx_baud     <= w_rx_baud_nx;
      r_rx_bit      <= w_rx_bit_nx;
      r_rx_shift    <= w_rx_shift_nx;
      r_rx_par_bit  <= w_rx_par_bit_nx;
      // A set event wins over a simultaneous clear.
      r_framing_err <= w_set_frame | (r_framing_err & ~err_clear);
      r_parity_err  <= w_set_par   | (r_parity_err  & ~err_clear);
      r_overrun_err <= w_set_ovr   | (r_overrun_err & ~err_clear);
    end
  end

  assign framing_err = r_framing_err;
  assign parity_err  = r_parity_err;
  assign overrun_err = r_overrun_err;

endmodule

`default_nettype wire
